rgb_out_buffer: RTL

- Output elastic buffer that sits directly downstream of the RGB processing wrapper's output stage.
- Accepts the valid/ready RGB pixel stream and stores it in a FIFO.
- Drains the FIFO at a fixed pixel cadence set by a pixel-enable strobe, driving the video output.
- Aligns output start to a frame boundary and flags underflow. On underflow it blanks the output and resynchronises to the next frame.

---
 rtl/rgb_out_buffer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/rgb_out_buffer.sv
// rgb_out_buffer
//   Output elastic buffer for the RGB pipeline. Pixels arrive on a valid/ready
//   stream and are stored in a FIFO. The FIFO is drained at a fixed pixel
//   cadence set by pix_en_i. Output starts on a frame boundary (vsync=1 entry)
//   once StartLevel entries are buffered. If the FIFO runs dry, the output is
//   blanked, the underflow is flagged and counted, and the buffer waits for the
//   next frame start.
//
// Ports
//   clk_i, rst_i         clock, synchronous active-high reset
//   rgb_i, hsync_i, vsync_i, vde_i, valid_i / ready_o
//                        input pixel stream (valid/ready handshake)
//   pix_en_i             pixel-rate strobe, one output pixel per asserted cycle
//   rgb_o, hsync_o, vsync_o, vde_o
//                        registered video output
//   level_o              FIFO occupancy
//   underflow_o          one-cycle pulse on underflow
//   underflow_cnt_o      saturating underflow count
module rgb_out_buffer #(
  parameter int Width      = 24,
  parameter int Depth      = 16,
  parameter int StartLevel = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [Width-1:0]           rgb_i,
  input  logic                       hsync_i,
  input  logic                       vsync_i,
  input  logic                       vde_i,
  input  logic                       valid_i,
  output logic                       ready_o,
  input  logic                       pix_en_i,
  output logic [Width-1:0]           rgb_o,
  output logic                       hsync_o,
  output logic                       vsync_o,
  output logic                       vde_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       underflow_o,
  output logic [15:0]                underflow_cnt_o
);

  localparam int AW = $clog2(Depth);
  localparam int CW = AW + 1;
  localparam int EW = Width + 3;

  typedef enum logic [1:0] {SYNC, FILL, RUN} state_t;

  state_t          state;
  logic [EW-1:0]   mem [Depth];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;
  logic            push;
  logic            pop;
  logic            empty;
  logic [EW-1:0]   head;
  logic [Width-1:0] head_rgb;
  logic            head_hsync;
  logic            head_vsync;
  logic            head_vde;

  // ready comes only from the registered count, so a pop in a full cycle
  // cannot open the write side in that same cycle.
  assign ready_o = (count != CW'(Depth));
  assign push    = valid_i & ready_o;
  assign empty   = (count == '0);
  assign level_o = count;

  assign head       = mem[rd_ptr];
  assign head_rgb   = head[EW-1:3];
  assign head_hsync = head[2];
  assign head_vsync = head[1];
  assign head_vde   = head[0];

  always_comb begin
    // NOTE: every signal driven from always_comb gets a default first so no
    // path through the case leaves it unassigned (which would infer a latch).
    pop = 1'b0;
    unique case (state)
      SYNC:    pop = ~empty & ~head_vsync;   // discard until a frame start
      FILL:    pop = 1'b0;
      RUN:     pop = pix_en_i & ~empty;
      default: pop = 1'b0;
    endcase
  end

  // NOTE: the storage array has no reset; the pointers and count define
  // which entries are valid, so clearing the data would only add logic.
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= {rgb_i, hsync_i, vsync_i, vde_i};
  end

  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values, matching the hardware it describes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      state           <= SYNC;
      rgb_o           <= '0;
      hsync_o         <= 1'b0;
      vsync_o         <= 1'b0;
      vde_o           <= 1'b0;
      underflow_o     <= 1'b0;
      underflow_cnt_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);

      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      underflow_o <= 1'b0;

      unique case (state)
        SYNC: begin
          rgb_o   <= '0;
          hsync_o <= 1'b0;
          vsync_o <= 1'b0;
          vde_o   <= 1'b0;
          if (!empty && head_vsync) state <= FILL;
        end
        FILL: begin
          rgb_o   <= '0;
          hsync_o <= 1'b0;
          vsync_o <= 1'b0;
          vde_o   <= 1'b0;
          if (count >= CW'(StartLevel)) state <= RUN;
        end
        RUN: begin
          if (pix_en_i) begin
            if (!empty) begin
              rgb_o   <= head_rgb;
              hsync_o <= head_hsync;
              vsync_o <= head_vsync;
              vde_o   <= head_vde;
            end else begin
              // Ran dry: blank, flag, and wait for the next frame start.
              rgb_o       <= '0;
              hsync_o     <= 1'b0;
              vsync_o     <= 1'b0;
              vde_o       <= 1'b0;
              underflow_o <= 1'b1;
              if (underflow_cnt_o != 16'hFFFF)
                underflow_cnt_o <= underflow_cnt_o + 16'd1;
              state <= SYNC;
            end
          end
        end
        default: state <= SYNC;
      endcase
    end
  end

endmodule
